// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave controller.
// Command encodings match what the RAM decodes from rx_data[9:8].
package spi_pkg;

  localparam int ADDR_W     = 8;
  localparam int FRAME_BITS = ADDR_W + 2;

  localparam logic [1:0] WR_ADDR = 2'b00;
  localparam logic [1:0] WR_DATA = 2'b01;
  localparam logic [1:0] RD_ADDR = 2'b10;
  localparam logic [1:0] RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } state_t;

endpackage

// File: rtl/spi_slave_ctrl_piso.sv
// Parallel-load, MSB-first shift-out register for the MISO path.
// done marks the cycle whose edge ends the byte and returns sdo to 0.
module spi_slave_ctrl_piso #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] din,
  output logic         sdo,
  output logic         done
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  sr;
  logic [CW-1:0] cnt;

  assign done = (cnt == CW'(1));

  // Load puts the MSB on the wire at once; each later edge advances one bit
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sr  <= '0;
      cnt <= '0;
      sdo <= 1'b0;
    end else if (load) begin
      sdo <= din[W-1];
      sr  <= {din[W-2:0], 1'b0};
      cnt <= CW'(W);
    end else if (cnt != '0) begin
      sdo <= done ? 1'b0 : sr[W-1];
      sr  <= {sr[W-2:0], 1'b0};
      cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/spi_slave_ctrl.sv
// SPI slave: deserialises 10-bit command frames for the RAM
// and serialises the RAM's read-data response onto MISO.
module spi_slave_ctrl
  import spi_pkg::*;
#(
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ss_n,
  input  logic                 mosi,
  output logic                 miso,
  output logic [ADDR_SIZE+1:0] rx_data,
  output logic                 rx_valid,
  input  logic [ADDR_SIZE-1:0] tx_data,
  input  logic                 tx_valid
);

  localparam int FW = ADDR_SIZE + 2;
  localparam int CW = $clog2(FW);

  state_t        state;
  state_t        nxt;
  logic [CW-1:0] bit_cnt;
  logic [FW-2:0] sh;
  logic [FW-1:0] word;
  logic          frame_done;
  logic          tx_loaded;
  logic          rd_addr_received;
  logic          in_shift;
  logic          shift_en;
  logic          last_bit;
  logic          load_en;
  logic          piso_clr;
  logic          piso_done;

  assign word = {sh, mosi};

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // Next-state: ss_n high always returns to IDLE
  always_comb begin
    nxt = state;
    if (state != IDLE && ss_n) begin
      nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (!ss_n) nxt = CHK_CMD;
        CHK_CMD: begin
          if (!mosi)                 nxt = WRITE;
          else if (rd_addr_received) nxt = READ_DATA;
          else                       nxt = READ_ADD;
        end
        default: nxt = state;
      endcase
    end
  end

  // Control decode for the shift and response paths
  always_comb begin
    in_shift = !ss_n &&
               (state == WRITE || state == READ_ADD ||
                state == READ_DATA);
    shift_en = in_shift && !frame_done;
    last_bit = shift_en && (bit_cnt == CW'(FW - 1));
    load_en  = in_shift && state == READ_DATA &&
               frame_done && !tx_loaded && tx_valid;
    piso_clr = ss_n || state != READ_DATA;
  end

  // Deserialiser, strobe and read-address bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt          <= '0;
      sh               <= '0;
      frame_done       <= 1'b0;
      tx_loaded        <= 1'b0;
      rd_addr_received <= 1'b0;
      rx_data          <= '0;
      rx_valid         <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (!in_shift) begin
        bit_cnt    <= '0;
        frame_done <= 1'b0;
        tx_loaded  <= 1'b0;
      end else if (shift_en) begin
        sh <= word[FW-2:0];
        if (last_bit) begin
          rx_data    <= word;
          rx_valid   <= 1'b1;
          bit_cnt    <= '0;
          frame_done <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + CW'(1);
        end
      end
      if (load_en)
        tx_loaded <= 1'b1;
      if (last_bit && state == READ_ADD)
        rd_addr_received <= 1'b1;
      if (piso_done && !piso_clr)
        rd_addr_received <= 1'b0;
    end
  end

  spi_slave_ctrl_piso #(
    .W(ADDR_SIZE)
  ) u_piso (
    .clk  (clk),
    .rst  (rst),
    .clr  (piso_clr),
    .load (load_en),
    .din  (tx_data),
    .sdo  (miso),
    .done (piso_done)
  );

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Self-checking bench for spi_slave_ctrl against a frame-level
// model of command decoding, read-address state and RAM contents.
module tb_spi_slave_ctrl;
  import spi_pkg::*;

  logic       clk;
  logic       rst;
  logic       ss_n;
  logic       mosi;
  logic       miso;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;

  int checks;
  int errors;

  logic [7:0] m_mem [256];
  logic [7:0] m_wa;
  logic [7:0] m_ra;
  bit         m_rar;

  spi_slave_ctrl #(.ADDR_SIZE(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .ss_n     (ss_n),
    .mosi     (mosi),
    .miso     (miso),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_bit(input string tag, input logic got,
                         input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic chk_word(input string tag, input logic [9:0] got,
                          input logic [9:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One frame: ss_n low, R/W bit, nbits of w (10 = complete), then
  // one cycle of ss_n high. A read-data frame also plays the RAM.
  task automatic frame(input logic rw, input logic [9:0] w,
                       input int nbits, input bit stray);
    bit         full;
    bit         rd;
    int         ncyc;
    int         idx;
    logic [7:0] b;
    logic       exp_miso;
    full = (nbits == 10);
    rd   = rw && m_rar;
    b    = m_mem[m_ra];
    if (!full)   ncyc = 2 + nbits;
    else if (rd) ncyc = 23;
    else         ncyc = 14;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      ss_n = 1'b0;
      idx  = c - 3;
      if (c == 2)
        mosi = rw;
      else if (c >= 3 && idx < nbits)
        mosi = w[9-idx];
      else
        mosi = 1'($urandom);
      if (rd && full && c == 14) begin
        tx_valid = 1'b1;
        tx_data  = b;
      end else if (rd && full && c == 15) begin
        tx_valid = 1'b1;
        tx_data  = ~b;
      end else begin
        tx_valid = stray;
        tx_data  = 8'($urandom);
      end
      @(posedge clk);
      #1;
      chk_bit("rx_valid", rx_valid, full && c == 12);
      if (full && c == 12)
        chk_word("rx_data", rx_data, w);
      exp_miso = 1'b0;
      if (rd && full && c >= 14 && c <= 21)
        exp_miso = b[21-c];
      chk_bit("miso", miso, exp_miso);
    end
    @(negedge clk);
    ss_n     = 1'b1;
    tx_valid = 1'b0;
    mosi     = 1'b0;
    @(posedge clk);
    #1;
    chk_bit("miso_gap", miso, 1'b0);
    chk_bit("rx_valid_gap", rx_valid, 1'b0);
    if (full) begin
      case (w[9:8])
        WR_ADDR: m_wa = w[7:0];
        WR_DATA: m_mem[m_wa] = w[7:0];
        RD_ADDR: m_ra = w[7:0];
        default: ;
      endcase
      if (rw && !m_rar) m_rar = 1'b1;
      else if (rd)      m_rar = 1'b0;
    end
  endtask

  initial begin
    logic       rw;
    logic [9:0] w;
    int         nb;
    bit         st;
    checks = 0;
    errors = 0;
    for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;
    m_wa  = 8'h00;
    m_ra  = 8'h00;
    m_rar = 1'b0;
    rst      = 1'b1;
    ss_n     = 1'b1;
    mosi     = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;

    repeat (2) @(posedge clk);
    #1;
    chk_bit("reset_miso", miso, 1'b0);
    chk_bit("reset_rx_valid", rx_valid, 1'b0);
    chk_word("reset_rx_data", rx_data, 10'h000);
    @(negedge clk);
    rst = 1'b0;

    // Write address, then R/W=1 must go to READ_ADD (no miso)
    frame(1'b0, 10'h0A5, 10, 1'b0);
    frame(1'b1, 10'h3C7, 10, 1'b0);
    frame(1'b1, 10'h311, 10, 1'b0);

    // Full write/read round trip: expect 0x3C on miso
    frame(1'b0, 10'h010, 10, 1'b0);
    frame(1'b0, 10'h13C, 10, 1'b0);
    frame(1'b1, 10'h210, 10, 1'b0);
    frame(1'b1, 10'h3E2, 10, 1'b0);

    // Aborts: partial frames, including on the 10th bit
    frame(1'b1, 10'h255, 6, 1'b0);
    frame(1'b0, 10'h07F, 10, 1'b0);
    frame(1'b1, 10'h210, 10, 1'b0);
    frame(1'b1, 10'h3AA, 6, 1'b0);
    frame(1'b1, 10'h3AA, 9, 1'b0);
    frame(1'b1, 10'h301, 10, 1'b0);

    // Stray tx_valid in WRITE and READ_ADD
    frame(1'b0, 10'h1C3, 10, 1'b1);
    frame(1'b1, 10'h210, 10, 1'b1);
    frame(1'b1, 10'h300, 10, 1'b0);

    // Randomised frames
    for (int k = 0; k < 30; k++) begin
      rw = 1'($urandom);
      w  = 10'($urandom);
      nb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 9) : 10;
      st = !(rw && m_rar) && ($urandom_range(0, 3) == 0);
      frame(rw, w, nb, st);
    end

    // Reset mid-frame
    @(negedge clk);
    ss_n = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      mosi = 1'($urandom);
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_bit("midrst_miso", miso, 1'b0);
    chk_bit("midrst_rx_valid", rx_valid, 1'b0);
    chk_word("midrst_rx_data", rx_data, 10'h000);
    @(negedge clk);
    rst  = 1'b0;
    ss_n = 1'b1;
    m_rar = 1'b0;
    for (int c = 0; c < 14; c++) begin
      @(posedge clk);
      #1;
      chk_bit("post_rst_rx_valid", rx_valid, 1'b0);
    end
    frame(1'b1, 10'h255, 10, 1'b0);
    frame(1'b1, 10'h3FF, 10, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
